// File: rtl/simon_sequencer.sv
// Simon game controller: seeds/rewinds/steps the PRNG, plays the sequence on
// the LEDs, then checks player presses against the same PRNG stream.
module simon_sequencer #(
  parameter int MAX_LEN     = 16,
  parameter int SHOW_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       button_valid,
  input  logic [1:0] button,
  input  logic [1:0] random,
  output logic       step,
  output logic       rerun,
  output logic       randomize,
  output logic       led_valid,
  output logic [1:0] led_color,
  output logic [4:0] level,
  output logic       win,
  output logic       fail,
  output logic       busy
);

  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_SEED, S_REW_SHOW, S_SHOW_ON, S_SHOW_OFF,
    S_REW_IN, S_WAIT_IN, S_ACCEPT, S_FAIL, S_WIN
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [4:0]    level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    idx_inc;

  assign idx_inc = idx_q + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      level_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEED;
      S_SEED: begin
        level_d = 5'd1;
        state_d = S_REW_SHOW;
      end
      S_REW_SHOW: begin
        idx_d   = '0;
        timer_d = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SHOW_OFF: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          idx_d   = idx_inc;
          state_d = (idx_inc == level_q) ? S_REW_IN : S_SHOW_ON;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_REW_IN: begin
        idx_d   = '0;
        state_d = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        if (button_valid) state_d = (button == random) ? S_ACCEPT : S_FAIL;
      end
      S_ACCEPT: begin
        idx_d = idx_inc;
        if (idx_inc < level_q) begin
          state_d = S_WAIT_IN;
        end else if (level_q == LEN_MAX) begin
          state_d = S_WIN;
        end else begin
          level_d = level_q + 5'd1;
          state_d = S_REW_SHOW;
        end
      end
      S_FAIL:  state_d = S_IDLE;
      S_WIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state; led_color forwards the PRNG color.
  always_comb begin
    step      = 1'b0;
    rerun     = 1'b0;
    randomize = 1'b0;
    led_valid = 1'b0;
    win       = 1'b0;
    fail      = 1'b0;
    case (state_q)
      S_SEED:     randomize = 1'b1;
      S_REW_SHOW: rerun = 1'b1;
      S_SHOW_ON: begin
        led_valid = 1'b1;
        step      = (timer_q == SHOW_LAST);
      end
      S_REW_IN:   rerun = 1'b1;
      S_ACCEPT:   step = 1'b1;
      S_FAIL:     fail = 1'b1;
      S_WIN:      win = 1'b1;
      default:    ;
    endcase
  end

  assign led_color = led_valid ? random : 2'd0;
  assign level     = level_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed-plus-random bench for simon_sequencer with a behavioural PRNG and
// expected timing derived from the game rules.
module tb_simon_sequencer;
  localparam int MAX_LEN = 3;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam logic [1:0] FIXED [4] = '{2'd2, 2'd0, 2'd3, 2'd1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       button_valid = 1'b0;
  logic [1:0] button = 2'd0;
  logic [1:0] random;
  logic       step, rerun, randomize, led_valid, win, fail, busy;
  logic [1:0] led_color;
  logic [4:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  simon_sequencer #(.MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .button_valid(button_valid),
    .button(button), .random(random), .step(step), .rerun(rerun),
    .randomize(randomize), .led_valid(led_valid), .led_color(led_color),
    .level(level), .win(win), .fail(fail), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural PRNG: first two games use the fixed stream, later ones random.
  logic [1:0] seq [8] = '{default: 2'd0};
  logic [2:0] pos = 3'd0;
  int         game_cnt = 0;
  assign random = seq[pos];

  always @(posedge clk) begin
    if (randomize) begin
      for (int i = 0; i < 8; i++)
        seq[i] <= (game_cnt < 2 && i < 4) ? FIXED[i] : 2'($urandom_range(0, 3));
      pos      <= 3'd0;
      game_cnt <= game_cnt + 1;
    end else if (rerun) begin
      pos <= 3'd0;
    end else if (step) begin
      pos <= pos + 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag, input int exp_level);
    check({tag, "_step"},      32'(step),      0);
    check({tag, "_rerun"},     32'(rerun),     0);
    check({tag, "_randomize"}, 32'(randomize), 0);
    check({tag, "_led_valid"}, 32'(led_valid), 0);
    check({tag, "_led_color"}, 32'(led_color), 0);
    check({tag, "_level"},     32'(level),     exp_level);
    check({tag, "_win"},       32'(win),       0);
    check({tag, "_fail"},      32'(fail),      0);
    check({tag, "_busy"},      32'(busy),      0);
  endtask

  task automatic start_game(input logic with_press);
    start        = 1'b1;
    button_valid = with_press;
    button       = 2'($urandom_range(0, 3));
    tick();
    start        = 1'b0;
    button_valid = 1'b0;
    check("seed_randomize", 32'(randomize), 1);
    check("seed_rerun",     32'(rerun),     0);
    check("seed_busy",      32'(busy),      1);
    check("seed_led",       32'(led_valid), 0);
  endtask

  // Plays one level: playback check, then presses (bad >= 0 injects a wrong one).
  task automatic do_level(input int lvl, input int bad, output logic done);
    done = 1'b0;
    tick();
    check("rew_show_rerun", 32'(rerun), 1);
    check("rew_show_step",  32'(step),  0);
    check("rew_show_level", 32'(level), lvl);
    check("rew_show_busy",  32'(busy),  1);
    for (int e = 0; e < lvl; e++) begin
      for (int c = 0; c < SHOW; c++) begin
        button_valid = ($urandom_range(0, 2) == 0);
        button       = 2'($urandom_range(0, 3));
        tick();
        check("show_led",   32'(led_valid), 1);
        check("show_color", 32'(led_color), 32'(seq[e]));
        check("show_step",  32'(step),      (c == SHOW - 1) ? 1 : 0);
        check("show_fail",  32'(fail),      0);
      end
      for (int g = 0; g < GAP; g++) begin
        button_valid = ($urandom_range(0, 2) == 0);
        button       = 2'($urandom_range(0, 3));
        tick();
        check("gap_led",   32'(led_valid), 0);
        check("gap_color", 32'(led_color), 0);
        check("gap_step",  32'(step),      0);
        check("gap_fail",  32'(fail),      0);
      end
    end
    button_valid = 1'b0;
    tick();
    check("rew_in_rerun", 32'(rerun),     1);
    check("rew_in_step",  32'(step),      0);
    check("rew_in_led",   32'(led_valid), 0);
    for (int p = 0; p < lvl; p++) begin
      tick();
      button_valid = 1'b0;
      check("wait_busy",  32'(busy),  1);
      check("wait_step",  32'(step),  0);
      check("wait_rerun", 32'(rerun), 0);
      repeat ($urandom_range(0, 2)) begin
        start = ($urandom_range(0, 1) == 1);
        tick();
        start = 1'b0;
        check("wait_randomize", 32'(randomize), 0);
        check("wait_idle_step", 32'(step),      0);
        check("wait_idle_fail", 32'(fail),      0);
        check("wait_idle_busy", 32'(busy),      1);
      end
      button_valid = 1'b1;
      button = (p == bad) ? 2'(seq[p] + 2'($urandom_range(1, 3))) : seq[p];
      tick();
      button_valid = 1'b0;
      if (p == bad) begin
        check("bad_fail",  32'(fail),  1);
        check("bad_step",  32'(step),  0);
        check("bad_level", 32'(level), lvl);
        tick();
        check_idle_outs("after_fail", lvl);
        done = 1'b1;
        return;
      end
      check("accept_step", 32'(step), 1);
      check("accept_fail", 32'(fail), 0);
      check("accept_win",  32'(win),  0);
      if (p < lvl - 1 && $urandom_range(0, 1) == 1) begin
        button_valid = 1'b1;
        button       = seq[p + 1] ^ 2'd1;
      end
    end
    if (lvl == MAX_LEN) begin
      tick();
      check("win_pulse", 32'(win),   1);
      check("win_busy",  32'(busy),  1);
      check("win_level", 32'(level), lvl);
      check("win_step",  32'(step),  0);
      tick();
      check_idle_outs("after_win", lvl);
      done = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    int   bad_level;
    int   bad_pos;

    repeat (10) begin
      tick();
      check_idle_outs("reset", 0);
    end
    reset = 1'b1;
    tick();
    check_idle_outs("post_reset", 0);

    // Game 1: fixed stream 2,0,3,1, played to a win.
    start_game(1'b0);
    check("seed1_level", 32'(level), 0);
    for (int l = 1; l <= MAX_LEN; l++) do_level(l, -1, done);
    repeat (5) begin
      tick();
      check_idle_outs("hold_win", MAX_LEN);
    end

    // Game 2: start together with a press; wrong press at level 2, position 1.
    start_game(1'b1);
    check("seed2_level", 32'(level), MAX_LEN);
    do_level(1, -1, done);
    do_level(2, 1, done);
    repeat (3) begin
      tick();
      check_idle_outs("hold_fail", 2);
    end

    // Game 3: asynchronous reset in the middle of a SHOW_ON cycle.
    start_game(1'b0);
    tick();
    tick();
    tick();
    check("pre_reset_led", 32'(led_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("async_led",   32'(led_valid), 0);
    check("async_color", 32'(led_color), 0);
    check("async_level", 32'(level),     0);
    check("async_busy",  32'(busy),      0);
    repeat (2) begin
      tick();
      check_idle_outs("in_reset", 0);
    end
    reset = 1'b1;
    tick();
    check_idle_outs("after_reset", 0);

    // Random games on random streams with an optional wrong press.
    for (int g = 0; g < 6; g++) begin
      start_game(1'b0);
      bad_level = $urandom_range(1, MAX_LEN + 1);
      bad_pos   = (bad_level <= MAX_LEN) ? $urandom_range(0, bad_level - 1) : -1;
      for (int l = 1; l <= MAX_LEN; l++) begin
        do_level(l, (l == bad_level) ? bad_pos : -1, done);
        if (done) break;
      end
      repeat ($urandom_range(1, 3)) begin
        tick();
        check("rand_idle_busy", 32'(busy), 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
